// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side streamer: buffer state encoding
// and the width of the accepted-beat statistics counter.
package fifo_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_t;

    localparam int WC_W = 16;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry output buffer between the FIFO pop side and the stream side.
// The oldest entry always sits in head_buf so the stream sees it directly.
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  xfer,
    output logic [1:0]            cur_state,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] head
);

    buf_state_t            state;
    buf_state_t            next_state;
    logic [DATA_WIDTH-1:0] head_buf;
    logic [DATA_WIDTH-1:0] tail_buf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            EMPTY: if (pop) next_state = ONE;
            ONE: begin
                if (pop && !xfer) begin
                    next_state = TWO;
                end else if (!pop && xfer) begin
                    next_state = EMPTY;
                end
            end
            TWO:     if (xfer) next_state = ONE;
            default: next_state = EMPTY;
        endcase
        if (flush) begin
            next_state = EMPTY;
        end
    end

    // Payload registers carry no reset; occupancy is tracked by state alone.
    always_ff @(posedge clk) begin
        case (state)
            EMPTY: if (pop) head_buf <= in_data;
            ONE: begin
                if (pop && xfer) begin
                    head_buf <= in_data;
                end else if (pop) begin
                    tail_buf <= in_data;
                end
            end
            TWO:     if (xfer) head_buf <= tail_buf;
            default: ;
        endcase
    end

    assign cur_state = state;
    assign valid     = rst_n & (state != EMPTY);
    assign head      = rst_n ? head_buf : '0;

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a FIFO read port into a valid/ready packet stream with m_last framing.
// Define FIFO_RD_STATS_EN to enable the saturating word_count statistic.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = 4
) (
    input  logic                  r_clk,
    input  logic                  r_rst_n,
    input  logic                  r_empty,
    input  logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_en,
    input  logic                  drain_en,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [WC_W-1:0]       word_count
);

    localparam int                CNT_W     = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PKT_LEN - 1);

    logic [1:0]       state;
    logic             xfer;
    logic [CNT_W-1:0] beat_cnt;

    // Pop decision looks only at buffer occupancy, never at m_ready.
    assign r_en = r_rst_n & drain_en & ~r_empty & ~flush & (state != TWO);
    assign xfer = m_valid & m_ready;

    fifo_rd_skid #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk      (r_clk),
        .rst_n    (r_rst_n),
        .flush    (flush),
        .pop      (r_en),
        .in_data  (r_data),
        .xfer     (xfer),
        .cur_state(state),
        .valid    (m_valid),
        .head     (m_data)
    );

    always_ff @(posedge r_clk) begin
        if (!r_rst_n || flush) begin
            beat_cnt <= '0;
        end else if (xfer) begin
            beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + CNT_W'(1);
        end
    end

    assign m_last = m_valid & (beat_cnt == LAST_BEAT);

`ifdef FIFO_RD_STATS_EN
    logic [WC_W-1:0] word_cnt;

    always_ff @(posedge r_clk) begin
        if (!r_rst_n) begin
            word_cnt <= '0;
        end else if (xfer && (word_cnt != {WC_W{1'b1}})) begin
            word_cnt <= word_cnt + WC_W'(1);
        end
    end

    assign word_count = word_cnt;
`else
    assign word_count = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: a small FIFO model feeds the read port and
// accepted beats are logged on the falling edge for comparison with fixed vectors.
module tb_fifo_rd_stream;

    logic        r_clk = 1'b0;
    logic        r_rst_n;
    logic        r_empty;
    logic [7:0]  r_data;
    logic        r_en;
    logic        drain_en;
    logic        flush;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_last;
    logic [15:0] word_count;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem [32];
    int         wr_ptr  = 0;
    int         rd_ptr  = 0;
    int         pops    = 0;
    int         cyc     = 0;
    int         pops_base;
    logic       endless = 1'b0;
    logic       pop_now = 1'b0;

    logic [7:0] got_d [$];
    logic       got_l [$];
    int         got_c [$];

    fifo_rd_stream #(.DATA_WIDTH(8), .PKT_LEN(4)) dut (
        .r_clk     (r_clk),
        .r_rst_n   (r_rst_n),
        .r_empty   (r_empty),
        .r_data    (r_data),
        .r_en      (r_en),
        .drain_en  (drain_en),
        .flush     (flush),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .word_count(word_count)
    );

    always #5 r_clk = ~r_clk;

    assign r_empty = !endless && (rd_ptr >= wr_ptr);
    assign r_data  = mem[rd_ptr % 32];

    always @(negedge r_clk) begin
        pop_now <= r_en && !r_empty;
        if (m_valid && m_ready) begin
            got_d.push_back(m_data);
            got_l.push_back(m_last);
            got_c.push_back(cyc);
        end
    end

    always @(posedge r_clk) begin
        cyc <= cyc + 1;
        if (pop_now) begin
            rd_ptr <= rd_ptr + 1;
            pops   <= pops + 1;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge r_clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        mem[wr_ptr % 32] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic clear_log();
        got_d.delete();
        got_l.delete();
        got_c.delete();
        pops_base = pops;
    endtask

    task automatic do_reset();
        r_rst_n = 1'b0;
        cycles(2);
        r_rst_n = 1'b1;
        clear_log();
    endtask

    task automatic test_reset();
        r_rst_n  = 1'b0;
        flush    = 1'b0;
        drain_en = 1'b1;
        m_ready  = 1'b1;
        clear_log();
        push(8'hA1);
        cycles(2);
        @(negedge r_clk);
        checks++; if (r_en !== 1'b0) begin failures++; $display("FAIL reset_r_en got=%b exp=0", r_en); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
        checks++; if (m_last !== 1'b0) begin failures++; $display("FAIL reset_m_last got=%b exp=0", m_last); end
        checks++; if (m_data !== 8'h00) begin failures++; $display("FAIL reset_m_data got=%h exp=00", m_data); end
        checks++; if (word_count !== 16'h0000) begin failures++; $display("FAIL reset_word_count got=%h exp=0000", word_count); end
        checks++; if (pops != pops_base) begin failures++; $display("FAIL reset_no_pop got=%0d exp=0", pops - pops_base); end
    endtask

    task automatic test_first_beat();
        @(posedge r_clk); #1;
        r_rst_n = 1'b1;
        @(negedge r_clk);
        checks++; if (r_en !== 1'b1) begin failures++; $display("FAIL first_r_en got=%b exp=1", r_en); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL first_pre_valid got=%b exp=0", m_valid); end
        @(negedge r_clk);
        checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL first_m_valid got=%b exp=1", m_valid); end
        checks++; if (m_data !== 8'hA1) begin failures++; $display("FAIL first_m_data got=%h exp=a1", m_data); end
        @(negedge r_clk);
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL first_drained got=%b exp=0", m_valid); end
        checks++; if (pops - pops_base != 1) begin failures++; $display("FAIL first_pops got=%0d exp=1", pops - pops_base); end
        @(posedge r_clk); #1;
    endtask

    task automatic test_stream();
        do_reset();
        m_ready  = 1'b1;
        drain_en = 1'b1;
        for (int i = 0; i < 8; i++) push(8'(i));
        cycles(12);
        checks++; if (got_d.size() != 8) begin failures++; $display("FAIL stream_count got=%0d exp=8", got_d.size()); end
        if (got_d.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                checks++; if (got_d[i] !== 8'(i)) begin failures++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, got_d[i], 8'(i)); end
                checks++; if (got_l[i] !== ((i % 4) == 3)) begin failures++; $display("FAIL stream_last[%0d] got=%b exp=%b", i, got_l[i], (i % 4) == 3); end
                checks++; if (got_c[i] - got_c[0] != i) begin failures++; $display("FAIL stream_gap[%0d] got=%0d exp=%0d", i, got_c[i] - got_c[0], i); end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
        cycles(6);
        @(negedge r_clk);
        checks++; if (pops - pops_base != 2) begin failures++; $display("FAIL bp_pops got=%0d exp=2", pops - pops_base); end
        checks++; if (r_en !== 1'b0) begin failures++; $display("FAIL bp_r_en got=%b exp=0", r_en); end
        checks++; if (dut.u_skid.state !== 2'd2) begin failures++; $display("FAIL bp_state got=%0d exp=2", dut.u_skid.state); end
        checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL bp_m_valid got=%b exp=1", m_valid); end
        checks++; if (m_data !== 8'h10) begin failures++; $display("FAIL bp_m_data got=%h exp=10", m_data); end
        cycles(3);
        @(negedge r_clk);
        checks++; if (m_data !== 8'h10) begin failures++; $display("FAIL bp_hold got=%h exp=10", m_data); end
        checks++; if (m_last !== 1'b0) begin failures++; $display("FAIL bp_hold_last got=%b exp=0", m_last); end
        @(posedge r_clk); #1;
        m_ready = 1'b1;
        cycles(8);
        checks++; if (got_d.size() != 5) begin failures++; $display("FAIL bp_count got=%0d exp=5", got_d.size()); end
        if (got_d.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                checks++; if (got_d[i] !== 8'h10 + 8'(i)) begin failures++; $display("FAIL bp_order[%0d] got=%h exp=%h", i, got_d[i], 8'h10 + 8'(i)); end
                checks++; if (got_l[i] !== (i == 3)) begin failures++; $display("FAIL bp_last[%0d] got=%b exp=%b", i, got_l[i], i == 3); end
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        m_ready = 1'b1;
        push(8'h20); push(8'h21);
        cycles(4);
        checks++; if (got_d.size() != 2) begin failures++; $display("FAIL flush_pre_count got=%0d exp=2", got_d.size()); end
        m_ready = 1'b0;
        push(8'h22); push(8'h23);
        cycles(4);
        push(8'h24);
        flush = 1'b1;
        @(negedge r_clk);
        checks++; if (r_en !== 1'b0) begin failures++; $display("FAIL flush_r_en got=%b exp=0", r_en); end
        @(posedge r_clk); #1;
        flush = 1'b0;
        clear_log();
        @(negedge r_clk);
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL flush_m_valid got=%b exp=0", m_valid); end
        @(posedge r_clk); #1;
        m_ready = 1'b1;
        push(8'h25); push(8'h26); push(8'h27);
        cycles(8);
        checks++; if (got_d.size() != 4) begin failures++; $display("FAIL flush_count got=%0d exp=4", got_d.size()); end
        if (got_d.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (got_d[i] !== 8'h24 + 8'(i)) begin failures++; $display("FAIL flush_data[%0d] got=%h exp=%h", i, got_d[i], 8'h24 + 8'(i)); end
                checks++; if (got_l[i] !== (i == 3)) begin failures++; $display("FAIL flush_last[%0d] got=%b exp=%b", i, got_l[i], i == 3); end
            end
        end
    endtask

    task automatic test_drain();
        do_reset();
        m_ready = 1'b0;
        push(8'h40); push(8'h41);
        cycles(4);
        drain_en = 1'b0;
        push(8'h42); push(8'h43);
        m_ready = 1'b1;
        @(negedge r_clk);
        checks++; if (r_en !== 1'b0) begin failures++; $display("FAIL drain_r_en got=%b exp=0", r_en); end
        cycles(5);
        @(negedge r_clk);
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL drain_m_valid got=%b exp=0", m_valid); end
        checks++; if (wr_ptr - rd_ptr != 2) begin failures++; $display("FAIL drain_fifo_level got=%0d exp=2", wr_ptr - rd_ptr); end
        checks++; if (pops - pops_base != 2) begin failures++; $display("FAIL drain_pops got=%0d exp=2", pops - pops_base); end
        checks++; if (got_d.size() != 2) begin failures++; $display("FAIL drain_count got=%0d exp=2", got_d.size()); end
        if (got_d.size() == 2) begin
            checks++; if (got_d[0] !== 8'h40 || got_d[1] !== 8'h41) begin failures++; $display("FAIL drain_data got=%h,%h exp=40,41", got_d[0], got_d[1]); end
        end
        @(posedge r_clk); #1;
        drain_en = 1'b1;
        cycles(5);
        checks++; if (got_d.size() != 4) begin failures++; $display("FAIL drain_resume_count got=%0d exp=4", got_d.size()); end
        if (got_d.size() == 4) begin
            checks++; if (got_d[3] !== 8'h43 || got_l[3] !== 1'b1) begin failures++; $display("FAIL drain_resume_last got=%h/%b exp=43/1", got_d[3], got_l[3]); end
        end
    endtask

    task automatic test_reset_midpacket();
        do_reset();
        m_ready = 1'b1;
        push(8'h50); push(8'h51);
        cycles(4);
        m_ready = 1'b0;
        push(8'h52); push(8'h53);
        cycles(4);
        r_rst_n = 1'b0;
        @(negedge r_clk);
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL midrst_m_valid got=%b exp=0", m_valid); end
        checks++; if (m_data !== 8'h00) begin failures++; $display("FAIL midrst_m_data got=%h exp=00", m_data); end
        checks++; if (r_en !== 1'b0) begin failures++; $display("FAIL midrst_r_en got=%b exp=0", r_en); end
        @(posedge r_clk); #1;
        r_rst_n = 1'b1;
        clear_log();
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(8'h54 + 8'(i));
        cycles(8);
        checks++; if (got_d.size() != 4) begin failures++; $display("FAIL midrst_count got=%0d exp=4", got_d.size()); end
        if (got_d.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (got_d[i] !== 8'h54 + 8'(i)) begin failures++; $display("FAIL midrst_data[%0d] got=%h exp=%h", i, got_d[i], 8'h54 + 8'(i)); end
                checks++; if (got_l[i] !== (i == 3)) begin failures++; $display("FAIL midrst_last[%0d] got=%b exp=%b", i, got_l[i], i == 3); end
            end
        end
    endtask

    task automatic test_stats();
`ifdef FIFO_RD_STATS_EN
        do_reset();
        m_ready = 1'b1;
        endless = 1'b1;
        cycles(70010);
        @(negedge r_clk);
        checks++; if (word_count !== 16'hFFFF) begin failures++; $display("FAIL stats_saturate got=%h exp=ffff", word_count); end
        @(posedge r_clk); #1;
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        @(negedge r_clk);
        checks++; if (word_count !== 16'hFFFF) begin failures++; $display("FAIL stats_flush got=%h exp=ffff", word_count); end
        @(posedge r_clk); #1;
        endless = 1'b0;
        r_rst_n = 1'b0;
        cycles(1);
        @(negedge r_clk);
        checks++; if (word_count !== 16'h0000) begin failures++; $display("FAIL stats_reset got=%h exp=0000", word_count); end
        r_rst_n = 1'b1;
`else
        @(negedge r_clk);
        checks++; if (word_count !== 16'h0000) begin failures++; $display("FAIL stats_tied got=%h exp=0000", word_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_first_beat();
        test_stream();
        test_backpressure();
        test_flush();
        test_drain();
        test_reset_midpacket();
        test_stats();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of FIFO read data and stream data.
REQ-002 Parameter PKT_LEN, default 4: beats per packet; m_last marks every PKT_LEN-th accepted beat; legal range 1..256.
REQ-003 r_clk  in  1  sole clock, rising edge; all logic in this domain.
REQ-004 r_rst_n  in  1  reset; synchronous, active-low.
REQ-005 r_empty  in  1  FIFO read-side empty flag.
REQ-006 r_data  in  DATA_WIDTH  FIFO head word; valid whenever r_empty=0.
REQ-007 r_en  out  1  FIFO pop; head pointer advances at the edge where r_en=1 and r_empty=0.
REQ-008 drain_en  in  1  1 = pop permitted; 0 = stop popping; buffered beats still drain.
REQ-009 flush  in  1  synchronous clear of buffer and beat counter.
REQ-010 m_valid  out  1  stream beat valid.
REQ-011 m_ready  in  1  downstream accepts; a beat transfers when m_valid=1 and m_ready=1.
REQ-012 m_data  out  DATA_WIDTH  stream payload.
REQ-013 m_last  out  1  final beat of packet.
REQ-014 word_count  out  16  accepted-beat counter (see Configuration).

Function
REQ-015 Two-entry output buffer, states EMPTY(0), ONE(1), TWO(2); m_valid=1 in ONE and TWO, and m_data/m_last come from the oldest entry.
REQ-016 r_en = drain_en & ~r_empty & ~flush & (state != TWO); r_en shall not depend combinationally on m_ready.
REQ-017 A pop captures r_data at the same edge; the beat is visible on m_valid/m_data on the next cycle (1-cycle latency from r_empty falling with the buffer EMPTY).
REQ-018 Transitions: EMPTY->ONE on pop; ONE->TWO on pop without transfer; ONE->EMPTY on transfer without pop; ONE->ONE on pop with transfer; TWO->ONE on transfer; TWO->TWO otherwise.
REQ-019 Throughput: with drain_en=1, r_empty=0 and m_ready=1 held, one beat per cycle indefinitely.
REQ-020 m_data and m_last shall hold stable while m_valid=1 and m_ready=0; beat order equals FIFO pop order; no beat is dropped or duplicated.
REQ-021 A beat counter of width ceil(log2(PKT_LEN)), minimum 1 bit, increments on each transfer and wraps to 0 after PKT_LEN-1; m_last = (counter == PKT_LEN-1) & m_valid.
REQ-022 PKT_LEN=1 makes m_last=1 on every valid beat.
REQ-023 flush=1: the next state is EMPTY and the beat counter is 0; no pop occurs that cycle; a transfer coincident with flush does not count.
REQ-024 drain_en falling mid-stream stops popping from the same cycle; buffered beats still transfer under m_ready.

Reset
REQ-025 With r_rst_n=0 at an edge: state EMPTY, beat counter 0, word_count 0.
REQ-026 During reset: r_en=0, m_valid=0, m_last=0; m_data=0.
REQ-027 Reset mid-packet discards buffered beats; the next packet starts at beat 0.

Configuration
REQ-028 Macro FIFO_RD_STATS_EN defined: word_count increments on each transfer, saturates at 16'hFFFF, is cleared by reset and is not cleared by flush.
REQ-029 Macro FIFO_RD_STATS_EN undefined: the word_count port is still present and tied to 0, and no counter logic exists.

Structure
REQ-030 Package fifo_pkg holds the buffer state encoding (EMPTY=2'd0, ONE=2'd1, TWO=2'd2) and the word_count width constant (16).
REQ-031 Buffer and state machine go in sub-module fifo_rd_skid (params DATA_WIDTH); beat counter, r_en logic and stats stay in fifo_rd_stream.

Verification
REQ-032 Reset then r_empty=0, r_data=8'hA1, drain_en=1, m_ready=1 -> r_en=1 on the first post-reset cycle; next cycle m_valid=1, m_data=8'hA1.
REQ-033 Stream 8 words 0x00..0x07, m_ready=1, PKT_LEN=4 -> 8 consecutive beats; m_last=1 on 0x03 and 0x07 only.
REQ-034 Backpressure: FIFO holds 5 words, m_ready=0 -> exactly 2 pops, state TWO, r_en=0, m_data stable at the first word; after m_ready=1 all 5 words arrive in order.
REQ-035 flush asserted after 2 beats of a packet, with 2 words buffered -> m_valid=0 next cycle; the next accepted beat has m_last=0, and m_last=1 on the 4th beat after the flush.
REQ-036 drain_en=0 with r_empty=0 -> r_en=0; buffered beats empty out; FIFO untouched.
REQ-037 Stats build: 70000 transfers -> word_count=16'hFFFF; a flush leaves it at 16'hFFFF; reset gives 0. Non-stats build: word_count=0 throughout.
